// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin process scheduler feeding id_proc to the
// address-partition adders. Slot 0 is the OS; user slots are 1..N_PROC-1.
// Optional macro QUANTUM_PROG_EN adds quantum_in[7:0], latched on carrega.
module escalonador_rr #(
  parameter int N_PROC  = 4,
  parameter int ID_W    = 2,
  parameter int QUANTUM = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              carrega,
  input  logic [N_PROC-1:0] mascara,
  input  logic              HALT,
  input  logic              WAIT,
  input  logic              READY,
`ifdef QUANTUM_PROG_EN
  input  logic [7:0]        quantum_in,
`endif
  output logic [ID_W-1:0]   id_proc,
  output logic              troca,
  output logic              ocioso,
  output logic [N_PROC-1:0] ativos
);

`ifdef QUANTUM_PROG_EN
  localparam int CW = 8;
`else
  localparam int CW = $clog2(QUANTUM);
`endif

  typedef enum logic [1:0] {OCIOSO, EXECUTA, ESPERA_IO, TROCA} estado_t;

  estado_t           estado, estado_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ID_W-1:0]   id_n, prox;
  logic [N_PROC-1:0] carga, sel, limpa, ativos_n;
  logic              achou, expira;

  // slot 0 can never be loaded
  assign carga  = mascara & ~N_PROC'(1);
  assign sel    = N_PROC'(1) << id_proc;
  assign ocioso = (estado == OCIOSO);

`ifdef QUANTUM_PROG_EN
  logic [7:0] q_lim;

  // programmable quantum; values below 2 are clamped to 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       q_lim <= 8'(QUANTUM);
    else if (carrega) q_lim <= (quantum_in < 8'd2) ? 8'd2 : quantum_in;
  end

  assign expira = (cnt == q_lim - 8'd1);
`else
  assign expira = (cnt == CW'(QUANTUM - 1));
`endif

  // next live slot after id_proc, wrapping N_PROC-1 -> 1, ending at id_proc
  always_comb begin
    int c;
    logic [N_PROC-1:0] sh;
    achou = 1'b0;
    prox  = '0;
    sh    = '0;
    c     = int'(id_proc);
    for (int k = 1; k < N_PROC; k++) begin
      c  = (c >= N_PROC - 1) ? 1 : c + 1;
      sh = ativos >> c;
      if (!achou && sh[0]) begin
        achou = 1'b1;
        prox  = ID_W'(c);
      end
    end
  end

  // next state, quantum counter, id and live-set update
  always_comb begin
    estado_n = estado;
    cnt_n    = cnt;
    id_n     = id_proc;
    limpa    = '0;
    case (estado)
      OCIOSO: begin
        id_n = '0;
        if (carrega && (carga != '0)) estado_n = TROCA;
      end
      EXECUTA: begin
        cnt_n = cnt + CW'(1);
        if (HALT) begin
          limpa    = sel;
          estado_n = TROCA;
        end else if (WAIT) begin
          cnt_n    = cnt;
          estado_n = ESPERA_IO;
        end else if (expira) begin
          estado_n = TROCA;
        end
      end
      ESPERA_IO: begin
        if (HALT) begin
          limpa    = sel;
          estado_n = TROCA;
        end else if (READY) begin
          estado_n = EXECUTA;
        end
      end
      TROCA: begin
        cnt_n = '0;
        if (achou) begin
          id_n     = prox;
          estado_n = EXECUTA;
        end else begin
          id_n     = '0;
          estado_n = OCIOSO;
        end
      end
      default: estado_n = OCIOSO;
    endcase
    // a new load beats a halt clear of the same bit
    if (estado == OCIOSO) ativos_n = carrega ? carga : ativos;
    else                  ativos_n = (ativos & ~limpa) | (carrega ? carga : '0);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado  <= OCIOSO;
      cnt     <= '0;
      id_proc <= '0;
      troca   <= 1'b0;
      ativos  <= '0;
    end else begin
      estado  <= estado_n;
      cnt     <= cnt_n;
      id_proc <= id_n;
      troca   <= (estado_n == TROCA);
      ativos  <= ativos_n;
    end
  end

endmodule

// File: doc/escalonador_rr.md
Name: escalonador_rr

Overview:
- Round-robin process scheduler placed directly upstream of the OS top level.
- Drives the `id_proc` consumed by the instruction/data address-partition adders (`soma_endereco_proc`).
- Consumes the CPU `HALT`/`WAIT` status and the operator `READY` confirm.
- Emits a one-cycle `troca` (context-switch) pulse so `controla_so` can re-enter BIOS/OS code.
- ID 0 is reserved for the OS. User processes are 1..N_PROC-1.

Parameters:
- N_PROC, 4, number of process slots including OS slot 0.
- ID_W, 2, width of id_proc; must satisfy 2**ID_W >= N_PROC.
- QUANTUM, 16, clk cycles a user process runs before preemption (>=2).

Ports:
- clk  in  1  system clock (divided 1 Hz/slow clock, same as CPU clk).
- reset  in  1  asynchronous, active-low reset.
- carrega  in  1  one-cycle pulse: latch mascara as the set of loaded processes.
- mascara  in  N_PROC  bit i=1 means process i is loaded; bit 0 ignored.
- HALT  in  1  current process executed halt.
- WAIT  in  1  current process blocked on input.
- READY  in  1  operator confirm; releases a WAIT.
- id_proc  out  ID_W  process currently owning the CPU (0 = OS).
- troca  out  1  one-cycle pulse when id_proc changes.
- ocioso  out  1  1 when no user process is runnable.
- ativos  out  N_PROC  live process set (bit 0 always 0).

Behaviour:
- Reset (async, reset=0): id_proc=0, troca=0, ocioso=1, ativos=0, quantum counter=0, state OCIOSO.
- States:
  - OCIOSO, EXECUTA, ESPERA_IO, TROCA.
  - OCIOSO: id_proc=0.
    - On carrega with any user bit set: ativos<=mascara&~1, then TROCA.
    - On carrega with no user bit set: ativos<=0, stay OCIOSO.
  - EXECUTA: counter increments each clk. Next-state priority, highest first:
    - HALT: clear ativos[id_proc], go TROCA.
    - WAIT: go ESPERA_IO; counter frozen.
    - counter==QUANTUM-1: go TROCA.
    - otherwise stay.
  - ESPERA_IO: counter held, id_proc held.
    - READY=1: go EXECUTA (counter resumes, not reset).
    - HALT=1: same as in EXECUTA; HALT wins over READY.
  - TROCA (exactly one cycle): troca=1, counter<=0.
    - Next id = first set bit of ativos searching id_proc+1 upward, wrapping N_PROC-1 -> 1, ending at id_proc itself.
    - Search skips bit 0.
    - If found: id_proc<=next, go EXECUTA.
    - If ativos==0: id_proc<=0, ocioso<=1, go OCIOSO.
- id_proc and troca are registered. id_proc changes on the clk edge that ends TROCA, so the new id is valid the cycle after troca=1.
- A single runnable process is re-selected on expiry: troca still pulses and id_proc is unchanged.
- carrega outside OCIOSO: ativos<=ativos|(mascara&~1); no state change. Already-running processes are not disturbed.
- carrega coinciding with a HALT clear of the same bit: the new load wins (bit stays 1).
- Out-of-range mascara bits (>=N_PROC) are not representable. With N_PROC<2**ID_W, id values >=N_PROC are never produced.
- ocioso = (state==OCIOSO).
- Reset mid-operation returns immediately to the reset values; ativos is lost.

Optional Feature:
- Macro QUANTUM_PROG_EN.
- Defined:
  - Adds input port quantum_in[7:0], latched on carrega.
  - Expiry compares against latched value-1.
  - quantum_in==0 or 1 is treated as 2.
  - Reset value of the latched quantum is QUANTUM.
- Undefined: port absent; fixed QUANTUM.

Test Plan:
- Reset, carrega with mascara=4'b1110 -> troca at cycle 1, id_proc=1 at cycle 2. Expiries then cycle id_proc 1->2->3->1 every QUANTUM+1 cycles, each with one troca pulse.
- Run id 2, assert HALT for one cycle -> ativos becomes 4'b1010, troca pulses, id_proc=3. Later rotation is 3->1->3.
- Run id 1, assert WAIT at count 5 -> ESPERA_IO, id_proc held 1 for 20 cycles. READY -> expiry occurs after QUANTUM-5 further cycles.
- HALT and counter==QUANTUM-1 in the same cycle -> the process bit is cleared and exactly one troca pulse occurs. Halting the last process gives id_proc=0 and ocioso=1.
- carrega mascara=4'b0001 from reset -> stays OCIOSO, ativos=0, no troca. Pulse reset low mid-EXECUTA -> id_proc=0 and ocioso=1 asynchronously, before the next clk edge.
- With QUANTUM_PROG_EN, quantum_in=4 -> preemption every 4 cycles of EXECUTA; quantum_in=0 -> every 2 cycles.
